// File: rtl/adsr_envelope.sv
// adsr_envelope
//   ADSR amplitude envelope generator with an integrated signed sample scaler.
//   Sits between the note sample source and the mixer. Every audio sample is
//   scaled by the current envelope gain, and the gain then advances one step
//   under a 5-state FSM. The FSM and the scaler act only on sample strobes.
//
//   Build option:
//     ENV_EXP_RELEASE_EN  defined   -> exponential release:
//                                      gain -= max(gain >> release_step[3:0], 1)
//                         undefined -> linear release: gain -= release_step
//
// Parameters
//   SAMPLE_W  width of the signed audio samples
//   GAIN_W    width of the unsigned gain; full scale is 2**GAIN_W-1
//
// Ports
//   clk              system clock
//   rst              asynchronous, active-high reset
//   sample_valid     one-cycle strobe per audio sample
//   sample_in        signed input sample, valid with sample_valid
//   note_on          one-cycle start/retrigger pulse, accepted on any cycle
//   gate             1 = note held, 0 = key released
//   attack_step      gain increment per strobe in ATTACK
//   decay_step       gain decrement per strobe in DECAY
//   sustain_level    gain held in SUSTAIN (read live)
//   release_step     linear step, or shift amount in exponential mode
//   sample_out       signed scaled sample, held between strobes
//   sample_out_valid high for one cycle, one cycle after each sample_valid
//   env_gain         current envelope gain register
//   env_state        IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
module adsr_envelope #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       note_on,
    input  logic                       gate,
    input  logic        [GAIN_W-1:0]   attack_step,
    input  logic        [GAIN_W-1:0]   decay_step,
    input  logic        [GAIN_W-1:0]   sustain_level,
    input  logic        [GAIN_W-1:0]   release_step,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic        [GAIN_W-1:0]   env_gain,
    output logic        [2:0]          env_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [GAIN_W-1:0] GAIN_ONE = {{(GAIN_W-1){1'b0}}, 1'b1};
    localparam int                PROD_W   = SAMPLE_W + GAIN_W + 1;

    state_t state;
    logic   note_pending;
    logic   note_seen;

    // A note_on arriving on the strobe cycle itself is consumed immediately.
    assign note_seen = note_pending | note_on;
    assign env_state = state;

    // Scaler: both operands are extended to the full product width (sample
    // sign-extended, gain zero-extended), so the modular product equals the
    // exact signed product. Taking bits [SAMPLE_W+GAIN_W-1:GAIN_W] is the
    // arithmetic shift right by GAIN_W (floor toward -inf), low SAMPLE_W kept.
    logic [PROD_W-1:0] prod;
    logic              unused_prod_bits;

    assign prod = {{(GAIN_W+1){sample_in[SAMPLE_W-1]}}, sample_in}
                * {{(SAMPLE_W+1){1'b0}}, env_gain};
    assign unused_prod_bits = ^{prod[PROD_W-1], prod[GAIN_W-1:0]};

    // ATTACK: one extra bit catches the carry for saturation.
    logic [GAIN_W:0] attack_sum;
    logic            attack_done;

    assign attack_sum  = {1'b0, env_gain} + {1'b0, attack_step};
    assign attack_done = (attack_step == '0) || (attack_sum >= {1'b0, GAIN_MAX});

    // DECAY: keep stepping only while the distance to the floor exceeds the step.
    logic [GAIN_W-1:0] decay_room;
    logic              decay_more;

    assign decay_room = env_gain - sustain_level;
    assign decay_more = (decay_step != '0) && (env_gain > sustain_level)
                     && (decay_room > decay_step);

    // RELEASE: decrement amount and the reach-zero condition.
    logic [GAIN_W-1:0] release_dec;
    logic              release_to_zero;

`ifdef ENV_EXP_RELEASE_EN
    logic [3:0]        release_shift;
    logic [GAIN_W-1:0] release_shr;
    logic              unused_release_bits;

    assign release_shift       = release_step[3:0];
    assign release_shr         = env_gain >> release_shift;
    assign release_dec         = (release_shr == '0) ? GAIN_ONE : release_shr;
    assign release_to_zero     = (release_shift == 4'd0) || (env_gain <= release_dec);
    assign unused_release_bits = ^release_step[GAIN_W-1:4];
`else
    assign release_dec     = release_step;
    assign release_to_zero = (release_step == '0) || (env_gain <= release_step);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            env_gain         <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            note_pending     <= 1'b0;
        end else begin
            sample_out_valid <= sample_valid;
            if (sample_valid) begin
                // Scaling uses the gain held before this strobe's update.
                sample_out   <= prod[SAMPLE_W+GAIN_W-1:GAIN_W];
                note_pending <= 1'b0;
                if (note_seen) begin
                    // Retrigger keeps the current gain to avoid a click.
                    state <= ATTACK;
                end else begin
                    case (state)
                        IDLE: begin
                            env_gain <= '0;
                        end
                        ATTACK: begin
                            if (!gate) begin
                                state <= RELEASE;
                            end else if (attack_done) begin
                                env_gain <= GAIN_MAX;
                                state    <= DECAY;
                            end else begin
                                env_gain <= attack_sum[GAIN_W-1:0];
                            end
                        end
                        DECAY: begin
                            if (!gate) begin
                                state <= RELEASE;
                            end else if (decay_more) begin
                                env_gain <= env_gain - decay_step;
                            end else begin
                                env_gain <= sustain_level;
                                state    <= SUSTAIN;
                            end
                        end
                        SUSTAIN: begin
                            if (!gate) begin
                                state <= RELEASE;
                            end else begin
                                env_gain <= sustain_level;
                            end
                        end
                        RELEASE: begin
                            // gate is ignored here; only note_on leaves early.
                            if (release_to_zero) begin
                                env_gain <= '0;
                                state    <= IDLE;
                            end else begin
                                env_gain <= env_gain - release_dec;
                            end
                        end
                        default: begin
                            env_gain <= '0;
                            state    <= IDLE;
                        end
                    endcase
                end
            end else if (note_on) begin
                note_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 8;

    logic                       clk;
    logic                       rst;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       note_on;
    logic                       gate;
    logic        [GAIN_W-1:0]   attack_step;
    logic        [GAIN_W-1:0]   decay_step;
    logic        [GAIN_W-1:0]   sustain_level;
    logic        [GAIN_W-1:0]   release_step;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_out_valid;
    logic        [GAIN_W-1:0]   env_gain;
    logic        [2:0]          env_state;

    int checks;
    int errors;

    adsr_envelope #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .note_on          (note_on),
        .gate             (gate),
        .attack_step      (attack_step),
        .decay_step       (decay_step),
        .sustain_level    (sustain_level),
        .release_step     (release_step),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .env_gain         (env_gain),
        .env_state        (env_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Gain and state after a strobe.
    task automatic check_env(input string tag, input int g, input int s);
        check({tag, " gain"}, {24'd0, env_gain}, g);
        check({tag, " state"}, {29'd0, env_state}, s);
    endtask

    // One strobe cycle; inputs change on the falling edge, results are read
    // 1 time unit after the rising edge.
    task automatic strobe(input logic n, input logic [15:0] s);
        @(negedge clk);
        sample_valid = 1'b1;
        note_on      = n;
        sample_in    = s;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        note_on      = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        sample_valid  = 1'b0;
        sample_in     = '0;
        note_on       = 1'b0;
        gate          = 1'b0;
        attack_step   = 8'd64;
        decay_step    = 8'd50;
        sustain_level = 8'd100;
        release_step  = 8'd40;

        idle_cycle();
        idle_cycle();
        check_env("reset", 0, 0);
        check("reset out", {16'd0, sample_out}, 32'h0);
        check("reset valid", {31'd0, sample_out_valid}, 0);
        @(negedge clk);
        rst  = 1'b0;
        gate = 1'b1;

        // Attack: 0,64,128,192,255 and DECAY on the saturating strobe.
        strobe(1'b1, 16'h0);
        check_env("atk0", 0, 1);
        strobe(1'b0, 16'h0);
        check_env("atk1", 64, 1);
        strobe(1'b0, 16'h0);
        check_env("atk2", 128, 1);
        strobe(1'b0, 16'h0);
        check_env("atk3", 192, 1);
        strobe(1'b0, 16'h0);
        check_env("atk4", 255, 2);

        // Decay to sustain 100: 205,155,105,100.
        strobe(1'b0, 16'h0);
        check_env("dec1", 205, 2);
        strobe(1'b0, 16'h0);
        check_env("dec2", 155, 2);
        strobe(1'b0, 16'h0);
        check_env("dec3", 105, 2);
        strobe(1'b0, 16'h0);
        check_env("dec4", 100, 3);
        strobe(1'b0, 16'h0);
        check_env("sus hold", 100, 3);

        // Scaling, using live sustain_level to set the gain.
        sustain_level = 8'd128;
        strobe(1'b0, 16'h4000);
        check("scale g100", {16'd0, sample_out}, 32'h1900);
        check_env("sus live", 128, 3);
        strobe(1'b0, 16'h4000);
        check("scale g128", {16'd0, sample_out}, 32'h2000);
        check("valid pulse", {31'd0, sample_out_valid}, 1);
        idle_cycle();
        check("valid drop", {31'd0, sample_out_valid}, 0);
        check("out hold", {16'd0, sample_out}, 32'h2000);
        sustain_level = 8'd255;
        strobe(1'b0, 16'h0);
        check_env("sus 255", 255, 3);
        strobe(1'b0, 16'h8000);
        check("scale min", {16'd0, sample_out}, 32'h8080);
        strobe(1'b0, 16'hFFFF);
        check("scale floor", {16'd0, sample_out}, 32'hFFFF);
        sustain_level = 8'd100;
        strobe(1'b0, 16'h0);
        check_env("sus back", 100, 3);

        // Release, then retrigger from a pending note_on.
        gate = 1'b0;
        strobe(1'b0, 16'h0);
        check_env("rel0", 100, 4);
        strobe(1'b0, 16'h0);
        check_env("rel1", 60, 4);
        gate = 1'b1;
        @(negedge clk);
        note_on = 1'b1;
        @(negedge clk);
        note_on = 1'b0;
        idle_cycle();
        idle_cycle();
        check_env("pending wait", 60, 4);
        strobe(1'b0, 16'h0);
        check_env("retrig", 60, 1);
        strobe(1'b0, 16'h0);
        check_env("rt1", 124, 1);
        strobe(1'b0, 16'h0);
        check_env("rt2", 188, 1);
        strobe(1'b0, 16'h0);
        check_env("rt3", 252, 1);
        strobe(1'b0, 16'h0);
        check_env("rt4", 255, 2);
        repeat (4) strobe(1'b0, 16'h0);
        check_env("rt sus", 100, 3);

        // Release: gate back high does not leave RELEASE.
        gate = 1'b0;
        strobe(1'b0, 16'h0);
        check_env("rl0", 100, 4);
        strobe(1'b0, 16'h0);
        check_env("rl1", 60, 4);
        gate = 1'b1;
        strobe(1'b0, 16'h0);
        check_env("rl gate hi", 20, 4);
        strobe(1'b0, 16'h0);
        check_env("rl idle", 0, 0);
        strobe(1'b0, 16'h0);
        check_env("idle stay", 0, 0);

        // note_on with gate low: ATTACK, then RELEASE, then IDLE.
        gate = 1'b0;
        strobe(1'b1, 16'h0);
        check_env("ng atk", 0, 1);
        strobe(1'b0, 16'h0);
        check_env("ng rel", 0, 4);
        strobe(1'b0, 16'h0);
        check_env("ng idle", 0, 0);

        // Zero steps: attack to MAX, decay to sustain, release to 0 at once.
        gate         = 1'b1;
        attack_step  = 8'd0;
        decay_step   = 8'd0;
        release_step = 8'd0;
        strobe(1'b1, 16'h0);
        check_env("z atk", 0, 1);
        strobe(1'b0, 16'h0);
        check_env("z max", 255, 2);
        strobe(1'b0, 16'h0);
        check_env("z sus", 100, 3);
        gate = 1'b0;
        strobe(1'b0, 16'h0);
        check_env("z rel", 100, 4);
        strobe(1'b0, 16'h0);
        check_env("z idle", 0, 0);

        // Async reset mid-attack at gain 128, with a note_on pending.
        gate         = 1'b1;
        attack_step  = 8'd64;
        release_step = 8'd40;
        strobe(1'b1, 16'h0);
        strobe(1'b0, 16'h0);
        strobe(1'b0, 16'h4000);
        check_env("pre rst", 128, 1);
        check("pre rst out", {16'd0, sample_out}, 32'h1000);
        @(negedge clk);
        note_on = 1'b1;
        @(posedge clk);
        #1;
        note_on = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_env("async rst", 0, 0);
        check("async rst out", {16'd0, sample_out}, 32'h0);
        check("async rst valid", {31'd0, sample_out_valid}, 0);
        idle_cycle();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("post rst valid", {31'd0, sample_out_valid}, 0);
        end
        strobe(1'b0, 16'h4000);
        check("post rst strobe", {31'd0, sample_out_valid}, 1);
        check_env("pending cleared", 0, 0);
        check("post rst out", {16'd0, sample_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
